// File: rtl/load_store_unit.sv
// Load/store unit: turns one CPU memory request into a single bus access,
// formatting byte/half/word data and reporting misalignment, illegal widths and bus timeouts.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic [1:0]        cause_q, cause_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              illegal, misaligned;
    logic [7:0]        loadByte;
    logic [15:0]       loadHalf;
    logic [31:0]       loadVal;
    logic [3:0]        laneBe;
    logic [31:0]       storeData;

    // Checks are made on the incoming request so a bad one never reaches the bus.
    assign illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && we);
    assign misaligned = ((funct3[1:0] == 2'b01) && addr[0])
                     || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    assign loadByte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign loadHalf = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        loadVal   = mem_rdata;
        laneBe    = 4'b1111;
        storeData = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                loadVal   = {{24{~funct3_q[2] & loadByte[7]}}, loadByte};
                laneBe    = 4'b0001 << addr_q[1:0];
                storeData = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                loadVal   = {{16{~funct3_q[2] & loadHalf[15]}}, loadHalf};
                laneBe    = addr_q[1] ? 4'b1100 : 4'b0011;
                storeData = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    we_d     = we;
                    funct3_d = funct3;
                    addr_d   = addr;
                    wdata_d  = wdata;
                    cnt_d    = '0;
                    if (illegal) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        cause_d = 2'b10;
                    end else if (misaligned) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        cause_d = 2'b01;
                    end else begin
                        state_d = ACCESS;
                        fault_d = 1'b0;
                        cause_d = 2'b00;
                    end
                end
            end
            ACCESS: begin
                // cnt_q holds the number of ACCESS cycles already elapsed without ack.
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = loadVal;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
            cause_q  <= 2'b00;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign fault       = done & fault_q;
    assign fault_cause = done ? cause_q : 2'b00;
    assign rdata       = rdata_q;
    assign mem_req     = (state_q == ACCESS);
    assign mem_we      = mem_req & we_q;
    assign mem_addr    = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_be      = mem_req ? laneBe : 4'b0000;
    assign mem_wdata   = mem_req ? storeData : 32'h0;
endmodule
